pipeline_signal_sequencer: RTL

- Sequential successor to the combinational per-stage control decoder.
- Tracks up to NUM_STAGES decoded instructions in flight: slot 0 = ID, slots 1..NUM_STAGES-3 = EX, slot NUM_STAGES-2 = MEM, slot NUM_STAGES-1 = WB.
- Drives every stage's control signals at the same time.
- Adds register RAW hazard stalls, IO wait-state handshake with timeout, and flush.

---
 rtl/pipeline_signal_sequencer_pkg.sv | 70 +++++++
 rtl/pipeline_signal_sequencer_io_wait_timer.sv | 33 +++
 rtl/pipeline_signal_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipeline_signal_sequencer_pkg.sv
// Shared opcode-group indices and group-to-control decode functions used by
// the legacy per-stage decoder and the pipeline signal sequencer.
package pipeline_signal_sequencer_pkg;

  // Bit positions inside the one-hot opcode group vector
  localparam int unsigned GROUP_ALU            = 0;
  localparam int unsigned GROUP_ALU_IMD        = 1;
  localparam int unsigned GROUP_ALU_TWO_OP     = 2;
  localparam int unsigned GROUP_LOAD           = 3;
  localparam int unsigned GROUP_LOAD_INDIRECT  = 4;
  localparam int unsigned GROUP_STORE          = 5;
  localparam int unsigned GROUP_STORE_INDIRECT = 6;
  localparam int unsigned GROUP_REGISTER       = 7;
  localparam int unsigned GROUP_IO_READ        = 8;
  localparam int unsigned GROUP_IO_WRITE       = 9;
  localparam int unsigned GROUP_COUNT          = 10;

  // Default register index width
  localparam int unsigned DEFAULT_REG_W = 5;

  typedef logic [GROUP_COUNT-1:0] group_t;

  // One-hot vector with only bit idx set
  function automatic group_t grp(input int unsigned idx);
    return group_t'(1) << idx;
  endfunction

  localparam group_t RR_READ_MASK  = grp(GROUP_ALU_TWO_OP) | grp(GROUP_LOAD_INDIRECT) |
                                     grp(GROUP_REGISTER)   | grp(GROUP_STORE)         |
                                     grp(GROUP_IO_WRITE);
  localparam group_t RD_READ_MASK  = grp(GROUP_ALU)            | grp(GROUP_ALU_IMD) |
                                     grp(GROUP_STORE_INDIRECT) | grp(GROUP_LOAD_INDIRECT);
  localparam group_t RD_WRITE_MASK = grp(GROUP_ALU)  | grp(GROUP_REGISTER) |
                                     grp(GROUP_LOAD) | grp(GROUP_IO_READ);
  localparam group_t IO_MASK       = grp(GROUP_IO_READ) | grp(GROUP_IO_WRITE);

  // Decode helpers; masks keep every group bit referenced
  function automatic logic dec_rr_read(input group_t g);
    return |(g & RR_READ_MASK);
  endfunction

  function automatic logic dec_rd_read(input group_t g);
    return |(g & RD_READ_MASK);
  endfunction

  function automatic logic dec_rd_write(input group_t g);
    return |(g & RD_WRITE_MASK);
  endfunction

  function automatic logic dec_mem_read(input group_t g);
    return |(g & grp(GROUP_LOAD));
  endfunction

  function automatic logic dec_mem_write(input group_t g);
    return |(g & grp(GROUP_STORE));
  endfunction

  function automatic logic dec_io_read(input group_t g);
    return |(g & grp(GROUP_IO_READ));
  endfunction

  function automatic logic dec_io_write(input group_t g);
    return |(g & grp(GROUP_IO_WRITE));
  endfunction

  function automatic logic dec_is_io(input group_t g);
    return |(g & IO_MASK);
  endfunction

endpackage

// File: rtl/pipeline_signal_sequencer_io_wait_timer.sv
// Wait-state counter for an IO access held in MEM. "active" means an IO
// instruction sits in MEM without io_ack. timeout fires on the IO_TIMEOUT-th
// unacknowledged MEM cycle; waiting is the resulting freeze request.
module pipeline_signal_sequencer_io_wait_timer #(
  parameter int IO_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic timeout,
  output logic waiting
);

  localparam int CW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

  logic [CW-1:0] count_q;

  // count_q holds the number of wait cycles already spent on this access
  assign timeout = active && (count_q == CW'(IO_TIMEOUT - 1));
  assign waiting = active && !timeout;

  // Count while waiting; any cycle the access advances (ack or abort) clears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (waiting) begin
      count_q <= count_q + CW'(1);
    end else begin
      count_q <= '0;
    end
  end

endmodule

// File: rtl/pipeline_signal_sequencer.sv
// Pipeline signal sequencer: tracks decoded instructions in slots ID, EX..,
// MEM, WB and drives every stage's control strobes from registered slot
// state, with RAW hazard stalls, IO wait states with timeout, and flush.
module pipeline_signal_sequencer
  import pipeline_signal_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int GROUP_W    = GROUP_COUNT,
  parameter int REG_W      = DEFAULT_REG_W,
  parameter int IO_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [GROUP_W-1:0] in_group,
  input  logic [REG_W-1:0]   in_rd,
  input  logic [REG_W-1:0]   in_rr,
  input  logic               flush,
  input  logic               io_ack,
  output logic               rr_read,
  output logic               rd_read,
  output logic               rd_write,
  output logic [REG_W-1:0]   wb_rd,
  output logic               mem_read,
  output logic               mem_write,
  output logic               io_read,
  output logic               io_write,
  output logic               stall,
  output logic               io_timeout
);

  localparam int unsigned LAST_EX = NUM_STAGES - 3;
  localparam int unsigned MEM     = NUM_STAGES - 2;
  localparam int unsigned WB      = NUM_STAGES - 1;

  typedef struct packed {
    logic               valid;
    logic [GROUP_W-1:0] group;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rr;
  } slot_t;

  slot_t slot_q [NUM_STAGES];
  slot_t slot_d [NUM_STAGES];
  logic  wb_kill_q;
  logic  wb_kill_d;

  slot_t id_s;
  slot_t mem_s;
  slot_t wb_s;
  logic  io_pending;
  logic  io_wait;
  logic  hazard;

  assign id_s  = slot_q[0];
  assign mem_s = slot_q[MEM];
  assign wb_s  = slot_q[WB];

  // Stage controls depend only on slot registers
  assign rr_read   = id_s.valid  && dec_rr_read(id_s.group);
  assign rd_read   = id_s.valid  && dec_rd_read(id_s.group);
  assign rd_write  = wb_s.valid  && dec_rd_write(wb_s.group) && !wb_kill_q;
  assign wb_rd     = wb_s.rd;
  assign mem_read  = mem_s.valid && dec_mem_read(mem_s.group);
  assign mem_write = mem_s.valid && dec_mem_write(mem_s.group);
  assign io_read   = mem_s.valid && dec_io_read(mem_s.group);
  assign io_write  = mem_s.valid && dec_io_write(mem_s.group);

  assign io_pending = mem_s.valid && dec_is_io(mem_s.group) && !io_ack;

  // A flush never restarts the count: the MEM access it would time is untouched
  pipeline_signal_sequencer_io_wait_timer #(
    .IO_TIMEOUT (IO_TIMEOUT)
  ) u_io_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (io_pending),
    .timeout (io_timeout),
    .waiting (io_wait)
  );

  // RAW check of ID sources against pending writers in EX..MEM (WB writes through)
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 1; i <= MEM; i++) begin
      if (slot_q[i].valid && dec_rd_write(slot_q[i].group) &&
          ((rr_read && (id_s.rr == slot_q[i].rd)) ||
           (rd_read && (id_s.rd == slot_q[i].rd)))) begin
        hazard = 1'b1;
      end
    end
  end

  assign in_ready = !io_wait && !hazard;
  assign stall    = io_wait || hazard;

  // Slot advance: IO wait freezes ID..MEM, hazard freezes ID only, flush
  // empties ID..EX and the slot EX would have filled in MEM
  always_comb begin
    slot_d    = slot_q;
    wb_kill_d = wb_kill_q;
    if (io_wait) begin
      slot_d[WB] = '0;
      wb_kill_d  = 1'b0;
    end else begin
      slot_d[WB] = slot_q[MEM];
      wb_kill_d  = io_timeout && dec_io_read(mem_s.group);
      for (int unsigned i = 2; i <= MEM; i++) begin
        slot_d[i] = slot_q[i-1];
      end
      slot_d[1] = hazard ? '0 : slot_q[0];
      if (!hazard) begin
        if (in_valid) begin
          slot_d[0] = '{valid: 1'b1, group: in_group, rd: in_rd, rr: in_rr};
        end else begin
          slot_d[0] = '0;
        end
      end
    end
    if (flush) begin
      for (int unsigned i = 0; i <= LAST_EX; i++) begin
        slot_d[i] = '0;
      end
      if (!io_wait) begin
        slot_d[MEM] = '0;
      end
    end
  end

  // Slot registers; reset empties the pipeline and drops any IO access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        slot_q[i] <= '0;
      end
      wb_kill_q <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      wb_kill_q <= wb_kill_d;
    end
  end

endmodule
